// File: rtl/sca_cipher_wrapper.sv
// Host-side wrapper for a SASEBO-GIII cipher core: plaintext queue, per-block
// repeat/chaining and a scope trigger framing each core encryption.
module sca_cipher_wrapper #(
    parameter int DW    = 128,
    parameter int KW    = 128,
    parameter int DEPTH = 4,
    parameter int RPT_W = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             EN,
    input  logic [KW-1:0]    Kin,
    input  logic             Krdy,
    output logic             Kvld,
    input  logic [DW-1:0]    Din,
    input  logic             Drdy,
    output logic [DW-1:0]    Dout,
    output logic             Dvld,
    output logic             BSY,
    input  logic [RPT_W-1:0] rpt,
    input  logic             chain,
    output logic             trig,
    output logic [KW-1:0]    core_kin,
    output logic             core_krdy,
    input  logic             core_kvld,
    output logic [DW-1:0]    core_din,
    output logic             core_drdy,
    input  logic [DW-1:0]    core_dout,
    input  logic             core_dvld,
    input  logic             core_bsy,
    output logic             core_en
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, KEYW, ISSUE, RUN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic             key_ok_q, key_ok_d;
    logic [RPT_W-1:0] rem_q, rem_d;
    logic             chain_q, chain_d;
    logic [DW-1:0]    work_q, work_d;
    logic [KW-1:0]    core_kin_q, core_kin_d;
    logic [DW-1:0]    core_din_q, core_din_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             core_krdy_q, core_krdy_d;
    logic             core_drdy_q, core_drdy_d;
    logic             kvld_q, kvld_d;
    logic             dvld_q, dvld_d;
    logic             trig_q, trig_d;

    logic full, empty, push;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = EN && Drdy && !full;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        key_ok_d    = key_ok_q;
        rem_d       = rem_q;
        chain_d     = chain_q;
        work_d      = work_q;
        core_kin_d  = core_kin_q;
        core_din_d  = core_din_q;
        dout_d      = dout_q;
        core_krdy_d = 1'b0;
        core_drdy_d = 1'b0;
        kvld_d      = 1'b0;
        dvld_d      = 1'b0;
        trig_d      = trig_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (EN && Krdy) begin
                    core_kin_d  = Kin;
                    core_krdy_d = 1'b1;
                    key_ok_d    = 1'b0;
                    state_d     = KEYW;
                end else if (EN && key_ok_q && !empty && !core_bsy) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    work_d   = mem_q[rd_ptr_q[AW-1:0]];
                    rem_d    = (rpt == '0) ? RPT_W'(1) : rpt;
                    chain_d  = chain;
                    state_d  = ISSUE;
                end
            end
            KEYW: begin
                if (core_kvld) begin
                    key_ok_d = 1'b1;
                    kvld_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            ISSUE: begin
                if (EN) begin
                    core_din_d  = work_q;
                    core_drdy_d = 1'b1;
                    trig_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (core_dvld) begin
                    trig_d = 1'b0;
                    if (rem_q == RPT_W'(1)) begin
                        dout_d  = core_dout;
                        dvld_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d   = rem_q - RPT_W'(1);
                        work_d  = chain_q ? core_dout : work_q;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            key_ok_q    <= 1'b0;
            rem_q       <= '0;
            chain_q     <= 1'b0;
            work_q      <= '0;
            core_kin_q  <= '0;
            core_din_q  <= '0;
            dout_q      <= '0;
            core_krdy_q <= 1'b0;
            core_drdy_q <= 1'b0;
            kvld_q      <= 1'b0;
            dvld_q      <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            key_ok_q    <= key_ok_d;
            rem_q       <= rem_d;
            chain_q     <= chain_d;
            work_q      <= work_d;
            core_kin_q  <= core_kin_d;
            core_din_q  <= core_din_d;
            dout_q      <= dout_d;
            core_krdy_q <= core_krdy_d;
            core_drdy_q <= core_drdy_d;
            kvld_q      <= kvld_d;
            dvld_q      <= dvld_d;
            trig_q      <= trig_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= Din;
        end
    end

    // Anything other than IDLE (key load included) refuses a new key.
    assign BSY       = full || (state_q != IDLE);
    assign Kvld      = kvld_q;
    assign Dvld      = dvld_q;
    assign Dout      = dout_q;
    assign trig      = trig_q;
    assign core_kin  = core_kin_q;
    assign core_krdy = core_krdy_q;
    assign core_din  = core_din_q;
    assign core_drdy = core_drdy_q;
    assign core_en   = EN;

endmodule

// File: tb/tb_sca_cipher_wrapper.sv
// Bench for sca_cipher_wrapper: a behavioural cipher core, a monitor logging the
// core and host handshakes, and a block-level model of repeat/chaining.
module tb_sca_cipher_wrapper;

    localparam int DW = 128, KW = 128, DEPTH = 4, RPT_W = 8;
    localparam int LAT = 11, KLAT = 10;
    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic CLK = 1'b0, RSTn = 1'b0, EN = 1'b1;
    logic [KW-1:0] Kin = '0;
    logic Krdy = 1'b0, Kvld, Drdy = 1'b0, Dvld, BSY, trig, chain = 1'b0;
    logic [DW-1:0] Din = '0, Dout;
    logic [RPT_W-1:0] rpt = 8'd1;
    logic [KW-1:0] core_kin;
    logic core_krdy, core_kvld = 1'b0, core_drdy, core_dvld = 1'b0, core_bsy, core_en;
    logic [DW-1:0] core_din, core_dout = '0;

    sca_cipher_wrapper #(.DW(DW), .KW(KW), .DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .Kin(Kin), .Krdy(Krdy), .Kvld(Kvld),
        .Din(Din), .Drdy(Drdy), .Dout(Dout), .Dvld(Dvld), .BSY(BSY), .rpt(rpt),
        .chain(chain), .trig(trig), .core_kin(core_kin), .core_krdy(core_krdy),
        .core_kvld(core_kvld), .core_din(core_din), .core_drdy(core_drdy),
        .core_dout(core_dout), .core_dvld(core_dvld), .core_bsy(core_bsy), .core_en(core_en)
    );

    always #5 CLK = ~CLK;

    // Stand-in cipher: returns the FIPS-197 ciphertext for the FIPS key/plaintext pair.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
        if (k == FK && p == FP) return FC;
        return ({p[94:0], p[127:95]} ^ k) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    // Core model
    logic [KW-1:0] c_key = '0;
    logic [DW-1:0] c_res = '0;
    int c_cnt = 0, k_cnt = 0;
    logic c_busy = 1'b0, hold_bsy = 1'b0;
    assign core_bsy = hold_bsy | c_busy;

    always @(posedge CLK) begin
        core_dvld <= 1'b0;
        core_kvld <= 1'b0;
        if (core_drdy) begin
            c_res  <= cipher(c_key, core_din);
            c_cnt  <= LAT - 1;
            c_busy <= 1'b1;
        end else if (c_cnt > 1) begin
            c_cnt <= c_cnt - 1;
        end else if (c_cnt == 1) begin
            c_cnt     <= 0;
            core_dvld <= 1'b1;
            core_dout <= c_res;
            c_busy    <= 1'b0;
        end
        if (core_krdy) begin
            c_key <= core_kin;
            k_cnt <= KLAT - 1;
        end else if (k_cnt > 1) begin
            k_cnt <= k_cnt - 1;
        end else if (k_cnt == 1) begin
            k_cnt     <= 0;
            core_kvld <= 1'b1;
        end
    end

    // Monitor
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [127:0] drdy_q[$], dout_q[$];
    int dvld_n = 0, kvld_n = 0, krdy_n = 0, trig_hi = 0, trig_rise = 0;
    int last_cdvld = -10, last_ckvld = -10, dvld_lat_bad = 0, kvld_lat_bad = 0, bsy_bad = 0;
    logic trig_prev = 1'b0, keyw = 1'b0;

    always @(negedge CLK) begin
        if (core_drdy) drdy_q.push_back(core_din);
        if (core_dvld) last_cdvld <= cyc;
        if (core_kvld) last_ckvld <= cyc;
        if (Dvld) begin
            dout_q.push_back(Dout);
            dvld_n <= dvld_n + 1;
            if (cyc != last_cdvld + 1) dvld_lat_bad <= dvld_lat_bad + 1;
        end
        if (Kvld) begin
            kvld_n <= kvld_n + 1;
            if (cyc != last_ckvld + 1) kvld_lat_bad <= kvld_lat_bad + 1;
        end
        if (core_krdy) krdy_n <= krdy_n + 1;
        if (trig) trig_hi <= trig_hi + 1;
        if (trig && !trig_prev) trig_rise <= trig_rise + 1;
        trig_prev <= trig;
        if (keyw && !Kvld && !BSY) bsy_bad <= bsy_bad + 1;
        if (Kvld) keyw <= 1'b0;
        else if (core_krdy) keyw <= 1'b1;
    end

    int n_chk = 0, n_fail = 0;
    logic [127:0] cur_key = '0;
    logic [127:0] exp_din[$], exp_dout[$];
    int b_drdy, b_dout, b_dvld, b_trig_hi, b_trig_rise;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [127:0] p);
        Din = p;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
    endtask

    task automatic begin_run();
        b_drdy = drdy_q.size();
        b_dout = dout_q.size();
        b_dvld = dvld_n;
        b_trig_hi = trig_hi;
        b_trig_rise = trig_rise;
        exp_din.delete();
        exp_dout.delete();
    endtask

    // Block-level model: n = max(rpt,1) encryptions, chained or repeated.
    task automatic expect_block(input logic [127:0] p, input int r, input bit c);
        int n;
        logic [127:0] x, y;
        n = (r == 0) ? 1 : r;
        x = p;
        for (int i = 0; i < n; i++) begin
            exp_din.push_back(x);
            y = cipher(cur_key, x);
            if (i == n - 1) exp_dout.push_back(y);
            else if (c) x = y;
        end
    endtask

    task automatic wait_dvld(input string tag, input int n);
        int b = 0;
        while ((dvld_n - b_dvld) < n && b < 1000) begin
            tick();
            b++;
        end
        repeat (3) tick();
        check_eq({tag, "_ndvld"}, 128'(dvld_n - b_dvld), 128'(n));
    endtask

    task automatic compare_run(input string tag);
        int nd;
        nd = exp_din.size();
        check_eq({tag, "_ndrdy"}, 128'(drdy_q.size() - b_drdy), 128'(nd));
        for (int i = 0; i < nd; i++)
            if (b_drdy + i < drdy_q.size())
                check_eq($sformatf("%s_din%0d", tag, i), drdy_q[b_drdy + i], exp_din[i]);
        for (int i = 0; i < exp_dout.size(); i++)
            if (b_dout + i < dout_q.size())
                check_eq($sformatf("%s_dout%0d", tag, i), dout_q[b_dout + i], exp_dout[i]);
        check_eq({tag, "_trig_windows"}, 128'(trig_rise - b_trig_rise), 128'(nd));
        check_eq({tag, "_trig_cycles"}, 128'(trig_hi - b_trig_hi), 128'(nd * (LAT + 1)));
        check_eq({tag, "_trig_low"}, 128'(trig), 128'(0));
        check_eq({tag, "_dvld_latency"}, 128'(dvld_lat_bad), 128'(0));
    endtask

    task automatic load_key(input logic [127:0] k);
        int b = 0, k0, r0;
        k0 = kvld_n;
        r0 = krdy_n;
        Kin = k;
        Krdy = 1'b1;
        tick();
        Krdy = 1'b0;
        while (kvld_n == k0 && b < 100) begin
            tick();
            b++;
        end
        tick();
        cur_key = k;
        check_eq("kvld_count", 128'(kvld_n - k0), 128'(1));
        check_eq("core_krdy_pulses", 128'(krdy_n - r0), 128'(1));
        check_eq("kvld_latency", 128'(kvld_lat_bad), 128'(0));
        check_eq("bsy_in_keyw", 128'(bsy_bad), 128'(0));
        check_eq("core_kin", core_kin, k);
    endtask

    task automatic single_run(input string tag, input logic [127:0] p, input int r, input bit c);
        rpt = 8'(r);
        chain = c;
        begin_run();
        expect_block(p, r, c);
        push(p);
        wait_dvld(tag, 1);
        compare_run(tag);
    endtask

    initial begin
        logic [127:0] blk[5];
        logic [127:0] p;

        repeat (3) tick();
        check_eq("rst_kvld", 128'(Kvld), 128'(0));
        check_eq("rst_dvld", 128'(Dvld), 128'(0));
        check_eq("rst_bsy", 128'(BSY), 128'(0));
        check_eq("rst_trig", 128'(trig), 128'(0));
        check_eq("rst_core_krdy", 128'(core_krdy), 128'(0));
        check_eq("rst_core_drdy", 128'(core_drdy), 128'(0));
        check_eq("rst_dout", Dout, 128'(0));
        check_eq("rst_core_kin", core_kin, 128'(0));
        check_eq("rst_core_din", core_din, 128'(0));
        check_eq("core_en", 128'(core_en), 128'(1));
        RSTn = 1'b1;
        tick();

        load_key(FK);
        single_run("fips", FP, 1, 1'b0);

        p = {$urandom, $urandom, $urandom, $urandom};
        single_run("chain3", p, 3, 1'b1);
        single_run("repeat3", p, 3, 1'b0);
        single_run("rpt0", {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
        for (int it = 0; it < 4; it++)
            single_run($sformatf("rand%0d", it), {$urandom, $urandom, $urandom, $urandom},
                       int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));

        // Fill the queue while the core reports busy; the fifth block must drop.
        load_key({$urandom, $urandom, $urandom, $urandom});
        rpt = 8'd1;
        chain = 1'b0;
        hold_bsy = 1'b1;
        begin_run();
        for (int i = 0; i < 5; i++) begin
            blk[i] = {$urandom, $urandom, $urandom, $urandom};
            Din = blk[i];
            Drdy = 1'b1;
            tick();
            if (i == 2) check_eq("bsy_after3", 128'(BSY), 128'(0));
            if (i == 3) check_eq("bsy_after4", 128'(BSY), 128'(1));
            if (i < 4) expect_block(blk[i], 1, 1'b0);
        end
        Drdy = 1'b0;
        repeat (5) tick();
        check_eq("full_no_issue", 128'(drdy_q.size() - b_drdy), 128'(0));
        hold_bsy = 1'b0;
        wait_dvld("full", 4);
        compare_run("full");

        // Data before a key waits in the queue, then runs once the key is loaded.
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        begin_run();
        p = {$urandom, $urandom, $urandom, $urandom};
        push(p);
        repeat (30) tick();
        check_eq("nokey_no_issue", 128'(drdy_q.size() - b_drdy), 128'(0));
        load_key({$urandom, $urandom, $urandom, $urandom});
        expect_block(p, 1, 1'b0);
        wait_dvld("nokey", 1);
        compare_run("nokey");

        // Reset during RUN: the late core result is ignored and the key is lost.
        begin_run();
        push({$urandom, $urandom, $urandom, $urandom});
        for (int b = 0; b < 50 && drdy_q.size() == b_drdy; b++) tick();
        repeat (3) tick();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        repeat (20) tick();
        check_eq("abort_dvld", 128'(dvld_n - b_dvld), 128'(0));
        check_eq("abort_trig", 128'(trig), 128'(0));
        check_eq("abort_bsy", 128'(BSY), 128'(0));
        p = {$urandom, $urandom, $urandom, $urandom};
        push(p);
        repeat (30) tick();
        check_eq("abort_keylost", 128'(drdy_q.size() - b_drdy), 128'(1));
        load_key({$urandom, $urandom, $urandom, $urandom});
        begin_run();
        expect_block(p, 1, 1'b0);
        wait_dvld("after_abort", 1);
        compare_run("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sca_cipher_wrapper.md
Name: sca_cipher_wrapper

Overview:
- Parametrised host-side wrapper for the SASEBO-GIII side-channel target.
- Sits between the host-interface controller (Kin/Din/Krdy/Drdy handshake) and any 128-bit-class block-cipher core exposing the same Kin/Din/Dout/Krdy/Drdy/Kvld/Dvld/EN/BSY contract.
- Adds a DEPTH-entry plaintext queue and a per-block repeat count with optional ciphertext chaining, so one host command yields N captured traces.
- Adds a scope trigger framing every core encryption.

Parameters:
DW, 128, block width (plaintext/ciphertext bits)
KW, 128, key width
DEPTH, 4, plaintext queue entries (power of two, >=2)
RPT_W, 8, width of repeat-count input

Ports:
CLK  in  1  system clock
RSTn  in  1  synchronous reset, active low
EN  in  1  wrapper/core enable
Kin  in  KW  key from host
Krdy  in  1  key-ready pulse from host
Kvld  out  1  key-loaded pulse to host
Din  in  DW  plaintext from host
Drdy  in  1  data-ready pulse from host
Dout  out  DW  ciphertext to host
Dvld  out  1  ciphertext-valid pulse to host
BSY  out  1  wrapper cannot accept Krdy/Drdy
rpt  in  RPT_W  encryptions per block; 0 treated as 1; sampled at pop of each entry
chain  in  1  1 = each repeat encrypts previous ciphertext; 0 = re-encrypt same plaintext; sampled with rpt
trig  out  1  scope trigger
core_kin  out  KW  key to core
core_krdy  out  1  key-ready pulse to core
core_kvld  in  1  core key-schedule done
core_din  out  DW  block to core
core_drdy  out  1  data-ready pulse to core
core_dout  in  DW  core ciphertext
core_dvld  in  1  core ciphertext valid
core_bsy  in  1  core busy
core_en  out  1  equals EN

Behaviour:
- Reset: on CLK edge with RSTn=0, all outputs and registers clear.
  - Kvld, Dvld, BSY, trig, core_krdy and core_drdy = 0; Dout, core_kin and core_din = 0.
  - Queue empty; key_ok = 0; FSM = IDLE; repeat counter = 0.
  - Reset mid-encryption aborts it; a later core_dvld is ignored until a new core_drdy is issued.
- Queue push: EN & Drdy & !full writes Din at the tail.
  - Drdy while full is dropped, with no other effect.
  - Push and pop in the same cycle are legal; count is unchanged.
- BSY = full | (state==KEYW) | (Krdy-blocked condition: state!=IDLE).
- FSM states:
  - IDLE:
    - EN & Krdy → register core_kin<=Kin, pulse core_krdy 1 cycle, clear key_ok, go KEYW. Krdy has priority over starting data.
    - Else EN & key_ok & !empty & !core_bsy → pop head, load work<=head, rem<=max(rpt,1), latch chain, go ISSUE.
  - KEYW: wait core_kvld → key_ok<=1, Kvld pulses 1 cycle (next cycle), go IDLE. Krdy is ignored in this state.
  - ISSUE: core_din<=work, core_drdy pulses 1 cycle, trig<=1, go RUN. EN low holds in ISSUE.
  - RUN: wait core_dvld (EN not required), then trig<=0.
    - If rem==1: Dout<=core_dout, Dvld pulses 1 cycle, go IDLE.
    - Else: rem<=rem-1; work<=chain?core_dout:work; go ISSUE (no host Dvld).
- Latency: core_drdy is 1 cycle after pop; trig rises with core_drdy and falls the cycle after core_dvld; Dvld is 1 cycle after final core_dvld.
- Krdy arriving while not IDLE is dropped; the host must poll BSY.
- Krdy with non-empty queue: the key reloads, then queued blocks run with the new key.
- Data with key_ok=0 stays queued until a key is loaded.
- rpt is RPT_W bits; maximum 2^RPT_W−1 repeats, with no wrap.
- Queue pointers are log2(DEPTH)+1 bits; full/empty are distinguished by the MSB.

Test Plan:
- Reset then Krdy with Kin=000102…0F, core_kvld 10 cycles later → core_krdy 1-cycle pulse; Kvld pulse exactly 1 cycle after core_kvld; BSY=1 throughout KEYW.
- Key loaded, rpt=1, Drdy with Din=00112233…FF, core model returns after 11 cycles → single core_drdy; trig high 12 cycles; Dout equals AES-128 FIPS-197 vector 69C4E0D8…C55A; one Dvld.
- rpt=3, chain=1, Din=P → core_din sequence P, E(P), E(E(P)); three trig windows; one Dvld with E³(P). With chain=0: core_din = P three times; Dout = E(P).
- Push 5 blocks back-to-back with DEPTH=4 while core busy → BSY rises after the 4th; 5th dropped; exactly 4 Dvld in FIFO order.
- Drdy before any key → no core_drdy. Then Krdy → Kvld, then the queued block runs automatically.
- RSTn=0 in RUN for 1 cycle, then core_dvld arrives → no Dvld; trig=0; queue empty; key_ok=0.
